// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter
//   Instruction memory shared between the IF-stage fetch port and a byte-stream
//   program loader. A load is a 16-bit little-endian word count followed by
//   that many little-endian 32-bit words. The core is held in reset for the
//   whole load and released afterwards, so fetch restarts at PC 0.
//
// Ports
//   clk, rst      clock; synchronous active-high reset (memory is not cleared)
//   fetch_pc      byte address from IF
//   fetch_instr   combinational instruction at fetch_pc (NOP unless running)
//   load_req      single-cycle request to start a load (only honoured in RUN)
//   byte_valid    loader byte strobe
//   byte_data     loader byte
//   byte_ready    byte accepted when byte_valid && byte_ready
//   core_hold     core reset/stall, high while loading
//   load_done     one-cycle pulse when a load completes
//   load_error    sticky, header count exceeded DEPTH
//   words_loaded  words written to memory by the last or current load
module imem_load_arbiter #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    input  logic        load_req,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {S_RUN, S_LEN0, S_LEN1, S_DATA, S_DONE} state_t;

    localparam logic [15:0] DEPTH_W  = 16'(DEPTH);
    localparam logic [29:0] DEPTH_PC = 30'(DEPTH);

    // Power-up contents come from the configuration image; rst leaves them alone.
    logic [31:0] mem [DEPTH] = '{default: NOP};

    state_t      state_q, state_d;
    logic        byte_ready_q, core_hold_q, load_done_q, load_error_q;
    logic [15:0] words_loaded_q;
    logic [15:0] count_q;
    logic [15:0] word_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] asm_q;

    logic        accept;
    logic        last_byte;
    logic        last_word;
    logic        wr_en;
    logic [31:0] wr_word;
    logic [15:0] hdr_count;

    assign accept    = byte_valid && byte_ready_q;
    assign last_byte = (byte_cnt_q == 2'd3);
    assign last_word = (word_cnt_q == count_q - 16'd1);
    assign hdr_count = {byte_data, count_q[7:0]};
    assign wr_word   = {byte_data, asm_q};
    assign wr_en     = (state_q == S_DATA) && accept && last_byte && (word_cnt_q < DEPTH_W);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:  if (load_req) state_d = S_LEN0;
            S_LEN0: if (accept) state_d = S_LEN1;
            S_LEN1: if (accept) state_d = (hdr_count == 16'd0) ? S_DONE : S_DATA;
            S_DATA: if (accept && last_byte && last_word) state_d = S_DONE;
            S_DONE: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up
    // with state_q on every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_RUN;
            byte_ready_q   <= 1'b0;
            core_hold_q    <= 1'b0;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            words_loaded_q <= '0;
            count_q        <= '0;
            word_cnt_q     <= '0;
            byte_cnt_q     <= '0;
            asm_q          <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
            core_hold_q  <= (state_d != S_RUN);
            load_done_q  <= (state_d == S_DONE);
            case (state_q)
                S_RUN: begin
                    if (load_req) begin
                        load_error_q   <= 1'b0;
                        words_loaded_q <= '0;
                        word_cnt_q     <= '0;
                        byte_cnt_q     <= '0;
                    end
                end
                S_LEN0: if (accept) count_q[7:0] <= byte_data;
                S_LEN1: begin
                    if (accept) begin
                        count_q[15:8] <= byte_data;
                        if (hdr_count > DEPTH_W) load_error_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: asm_q[7:0]   <= byte_data;
                            2'd1: asm_q[15:8]  <= byte_data;
                            2'd2: asm_q[23:16] <= byte_data;
                            default: begin
                                word_cnt_q <= word_cnt_q + 16'd1;
                                if (wr_en) words_loaded_q <= words_loaded_q + 16'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[word_cnt_q[AW-1:0]] <= wr_word;
    end

    always_comb begin
        fetch_instr = NOP;
        if (state_q == S_RUN && fetch_pc[31:2] < DEPTH_PC)
            fetch_instr = mem[fetch_pc[AW+1:2]];
    end

    assign byte_ready   = byte_ready_q;
    assign core_hold    = core_hold_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench for imem_load_arbiter: directed loads plus randomized
// loads with random byte gaps, stalls and ignored load_req pulses, checked
// against a word-array model of the instruction memory.
module tb_imem_load_arbiter;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        load_req;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    imem_load_arbiter #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_pc     (fetch_pc),
        .fetch_instr  (fetch_instr),
        .load_req     (load_req),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_cnt = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] prog [64];

    always @(negedge clk) if (load_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    // Checks that hold on every cycle of a load.
    task automatic hold_checks();
        fetch_pc = $urandom;
        #1;
        check("hold_core_hold", 32'(core_hold), 32'd1);
        check("hold_fetch_nop", fetch_instr, NOP);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned gap;
        int unsigned waited;
        gap    = $urandom_range(0, 2);
        waited = 0;
        if ($urandom_range(0, 15) == 0) gap = 10;
        for (int unsigned i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            load_req   = (gap == 10 && i == 5);
            @(negedge clk);
            load_req = 1'b0;
            hold_checks();
        end
        while (byte_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (byte_ready !== 1'b1) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = $urandom;
        hold_checks();
    endtask

    task automatic start_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        #1;
        check("start_core_hold", 32'(core_hold), 32'd1);
        check("start_byte_ready", 32'(byte_ready), 32'd1);
        check("start_err_clear", 32'(load_error), 32'd0);
        check("start_wl_clear", 32'(words_loaded), 32'd0);
    endtask

    task automatic verify_fetch();
        logic [31:0] far_pc;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fetch_pc   = 32'(i * 4) + 32'($urandom_range(0, 3));
            byte_valid = 1'($urandom_range(0, 1));
            byte_data  = $urandom;
            #1;
            check("fetch_word", fetch_instr, model_mem[i]);
        end
        fetch_pc = 32'h80;
        #1;
        check("fetch_0x80", fetch_instr, NOP);
        far_pc   = $urandom;
        fetch_pc = far_pc | 32'h0000_0080;
        #1;
        check("fetch_far", fetch_instr, NOP);
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_prog(input int unsigned cnt);
        int unsigned d0;
        logic [15:0] c16;
        logic [31:0] w;
        int unsigned exp_wl;
        d0  = done_cnt;
        c16 = 16'(cnt);
        start_load();
        send_byte(c16[7:0]);
        send_byte(c16[15:8]);
        for (int unsigned k = 0; k < cnt; k++) begin
            w = prog[k];
            for (int unsigned b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
            if (k < DEPTH) model_mem[k] = prog[k];
        end
        check("done_pulse_hi", 32'(load_done), 32'd1);
        check("done_ready_lo", 32'(byte_ready), 32'd0);
        exp_wl = (cnt > DEPTH) ? DEPTH : cnt;
        @(negedge clk);
        #1;
        check("release_core_hold", 32'(core_hold), 32'd0);
        check("release_done_lo", 32'(load_done), 32'd0);
        check("done_count", done_cnt - d0, 32'd1);
        check("words_loaded", 32'(words_loaded), exp_wl);
        check("load_error", 32'(load_error), 32'(cnt > DEPTH));
        verify_fetch();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        load_req   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        fetch_pc   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        repeat (3) @(negedge clk);
        // rst wins over a simultaneous load_req
        load_req = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        load_req = 1'b0;
        #1;

        // Reset state, no load
        check("rst_core_hold", 32'(core_hold), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        verify_fetch();

        // Three-word program
        prog[0] = 32'h00500093;
        prog[1] = 32'h00500113;
        prog[2] = 32'h00208463;
        load_prog(3);

        // Empty program
        load_prog(0);

        // Oversized program: 34 words, last two discarded
        for (int unsigned i = 0; i < 64; i++) prog[i] = $urandom;
        load_prog(34);

        // A clean load right after an error load clears the sticky flag
        for (int unsigned i = 0; i < 64; i++) prog[i] = $urandom;
        load_prog(5);

        // Reset after six data bytes: word 0 kept, partial word 1 dropped
        for (int unsigned i = 0; i < 64; i++) prog[i] = $urandom;
        begin
            logic [31:0] w0;
            logic [31:0] w1;
            w0 = prog[0];
            w1 = prog[1];
            start_load();
            send_byte(8'h03);
            send_byte(8'h00);
            for (int unsigned b = 0; b < 4; b++) send_byte(w0[8*b +: 8]);
            send_byte(w1[7:0]);
            send_byte(w1[15:8]);
            model_mem[0] = w0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("midrst_core_hold", 32'(core_hold), 32'd0);
            check("midrst_byte_ready", 32'(byte_ready), 32'd0);
            check("midrst_words_loaded", 32'(words_loaded), 32'd0);
            check("midrst_load_error", 32'(load_error), 32'd0);
            verify_fetch();
        end

        // Randomized loads
        for (int unsigned n = 0; n < 8; n++) begin
            int unsigned cnt;
            for (int unsigned i = 0; i < 64; i++) prog[i] = $urandom;
            cnt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            load_prog(cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
Owns the instruction memory and arbitrates it between two requesters: the IF-stage fetch port (combinational read by PC) and a byte-stream program loader (e.g. fed by a UART receiver). A small FSM accepts a length header and little-endian instruction words, writes them into memory, holds the core in reset while loading, then releases it so fetch restarts at PC 0. This lets the team reload programs on the FPGA without resynthesis.

Parameters:
DEPTH, 32, number of 32-bit instruction words in memory
AW, 5, word-index width, equal to clog2(DEPTH)
NOP, 32'h00000013, word returned for idle, out-of-range or blocked fetches and used as the power-up fill value

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
fetch_pc  in  32  byte address from IF; word index = fetch_pc[AW+1:2]
fetch_instr  out  32  instruction at fetch_pc
load_req  in  1  single-cycle request to start a program load
byte_valid  in  1  loader byte strobe
byte_data  in  8  loader byte
byte_ready  out  1  block accepts byte_data this cycle when byte_valid && byte_ready
core_hold  out  1  drives core reset and stall; high while loading
load_done  out  1  one-cycle pulse when a load completes
load_error  out  1  sticky; set when header count > DEPTH
words_loaded  out  16  words written to memory by the last or current load

Behaviour:
- Memory: DEPTH x 32. Every word is set to NOP at configuration. rst does not clear memory contents.
- Fetch read is combinational. fetch_instr = mem[fetch_pc[AW+1:2]] when state==RUN and fetch_pc>>2 < DEPTH. Otherwise fetch_instr = NOP.
- States: RUN, LEN0, LEN1, DATA, DONE.
- Reset values: state=RUN, byte_ready=0, core_hold=0, load_done=0, load_error=0, words_loaded=0, byte counter=0, word counter=0, count register=0.
- RUN: byte_ready=0, core_hold=0. If load_req=1: go to LEN0, clear load_error, clear words_loaded.
- LEN0: byte_ready=1, core_hold=1. On accepted byte: count[7:0]=byte. Go to LEN1.
- LEN1: byte_ready=1, core_hold=1. On accepted byte: count[15:8]=byte.
  - Full count 0: go directly to DONE.
  - Count > DEPTH: set load_error. Go to DATA.
  - Otherwise: go to DATA.
- DATA: byte_ready=1, core_hold=1.
  - Bytes assemble little-endian: byte 0 -> bits [7:0], byte 3 -> bits [31:24].
  - On the 4th accepted byte of a word, if word index < DEPTH: write mem[index] = assembled word, and increment words_loaded.
  - Words with index >= DEPTH are consumed and discarded, with no wrap-around.
  - After the last byte of word count-1: go to DONE.
- DONE: byte_ready=0, core_hold=1, load_done=1 for exactly this one cycle. Next state is RUN. The core leaves reset with PC 0 on the following cycle.
- Write latency: a word written on cycle N is readable by fetch from cycle N+1. Fetch is blocked during the load in any case.
- load_req while not in RUN is ignored.
- byte_valid while byte_ready=0 is dropped with no effect.
- Stalled byte stream (byte_valid low): the FSM waits indefinitely; partial-word bytes are retained.
- rst mid-load:
  - Return to RUN immediately with the reset values above.
  - A partially assembled word is discarded.
  - Words already written remain in memory.
- rst and load_req in the same cycle: rst wins.

Test Plan:
1. Reset, no load -> core_hold=0, byte_ready=0. fetch_pc=0 returns preloaded mem[0]. fetch_pc=0x80 returns NOP.
2. load_req, then bytes 03 00, then 93 00 50 00, 13 01 50 00, 63 84 20 00 -> mem[0..2] = 00500093, 00500113, 00208463. words_loaded=3. A single load_done pulse. core_hold falls the cycle after DONE. Fetch at PC 0/4/8 returns these words.
3. Header 00 00 -> LEN1 goes straight to DONE. load_done pulses. Memory unchanged. words_loaded=0.
4. Header count 0x0022 (34) followed by 136 bytes -> load_error=1, words_loaded=32, mem[31] = the 32nd word, extra 8 bytes consumed. load_done pulses once.
5. Assert rst after 6 data bytes -> state RUN, core_hold=0. mem[0] holds the new word; mem[1] is unchanged (partial word dropped). The next load_req clears load_error.
6. During DATA, hold byte_valid low for 10 cycles and pulse load_req -> no state change, no writes. Loading resumes correctly afterwards. fetch_instr=NOP throughout the load.
